// File: rtl/muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative multiply/divide unit.
// Operation codes follow the RISC-V M-extension funct3 encoding.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_signed_a(input muldiv_op_t op);
        logic r;
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        logic r;
        case (op)
            OP_MULH, OP_DIV, OP_REM: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit for the RV32M/RV64M operation set.
// Operands are taken as magnitudes, iterated XLEN cycles, then sign-corrected in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int CW = $clog2(XLEN) + 1;

    muldiv_state_t     state_r, state_s;
    muldiv_op_t        op_r, op_in_s;
    logic              sign_r;
    logic [CW-1:0]     cnt_r;
    logic [2*XLEN-1:0] acc_r, acc_step_s, mul_fix_s;
    logic [XLEN-1:0]   opnd_r, result_r;
    logic              in_ready_r, out_valid_r, in_ready_s, out_valid_s;

    logic              a_neg_s, b_neg_s, sign_in_s, div_zero_s, ovf_s, special_s, accept_s;
    logic [XLEN-1:0]   a_abs_s, b_abs_s, special_val_s, quo_fix_s, rem_fix_s, fix_val_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;

    // Operand decode, magnitudes, result sign and special-case detection at accept
    always_comb begin
        op_in_s    = muldiv_op_t'(op);
        a_neg_s    = is_signed_a(op_in_s) & a[XLEN-1];
        b_neg_s    = is_signed_b(op_in_s) & b[XLEN-1];
        a_abs_s    = a_neg_s ? ({XLEN{1'b0}} - a) : a;
        b_abs_s    = b_neg_s ? ({XLEN{1'b0}} - b) : b;
        sign_in_s  = is_rem(op_in_s) ? a_neg_s : (a_neg_s ^ b_neg_s);
        div_zero_s = is_div(op_in_s) & (b == {XLEN{1'b0}});
        ovf_s      = is_div(op_in_s) & is_signed_a(op_in_s)
                   & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == {XLEN{1'b1}});
        special_s  = div_zero_s | ovf_s;
        if (div_zero_s) begin
            special_val_s = is_rem(op_in_s) ? a : {XLEN{1'b1}};
        end else if (ovf_s) begin
            special_val_s = is_rem(op_in_s) ? {XLEN{1'b0}} : a;
        end else begin
            special_val_s = {XLEN{1'b0}};
        end
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
    // acc_r holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = acc_r[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (!is_div(op_r)) begin
            acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else if (div_diff_s[XLEN]) begin
            acc_step_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end else begin
            acc_step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and output selection for the FIX cycle
    always_comb begin
        mul_fix_s = sign_r ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
        quo_fix_s = sign_r ? ({XLEN{1'b0}} - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
        rem_fix_s = sign_r ? ({XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                        fix_val_s = mul_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val_s = mul_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_val_s = quo_fix_s;
            OP_REM, OP_REMU:               fix_val_s = rem_fix_s;
            default:                       fix_val_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides everything including a pending accept
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CW'(XLEN - 1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        in_ready_s  = (state_s == ST_IDLE);
        out_valid_s = (state_s == ST_DONE);
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Datapath registers: operand capture, iteration and result load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= OP_MUL;
            sign_r   <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r   <= op_in_s;
                        sign_r <= sign_in_s;
                        cnt_r  <= {CW{1'b0}};
                        acc_r  <= is_div(op_in_s) ? {{XLEN{1'b0}}, a_abs_s} : {{XLEN{1'b0}}, b_abs_s};
                        opnd_r <= is_div(op_in_s) ? b_abs_s : a_abs_s;
                        if (special_s) begin
                            result_r <= special_val_s;
                        end
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CW'(1);
                end
                ST_FIX: begin
                    result_r <= fix_val_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = (result_r == {XLEN{1'b0}});

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): driver pushes reference results,
// a negedge monitor compares result, zero and latency whenever out_valid is high.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, zero;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
        int          t;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: RISC-V M-extension semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sp;
        logic [63:0] up;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin up = {32'd0, x} * {32'd0, y}; r = up[31:0]; end
            3'd1: begin sp = sx * sy; up = sp; r = up[63:32]; end
            3'd2: begin sp = sx * longint'({32'd0, y}); up = sp; r = up[63:32]; end
            3'd3: begin up = {32'd0, x} * {32'd0, y}; r = up[63:32]; end
            3'd4: begin
                if (y == 32'd0) r = 32'hFFFFFFFF;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                else begin sp = sx / sy; up = sp; r = up[31:0]; end
            end
            3'd5: r = (y == 32'd0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                if (y == 32'd0) r = x;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
                else begin sp = sx % sy; up = sp; r = up[31:0]; end
            end
            default: r = (y == 32'd0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 32'd0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("issue_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        e.res = ref_model(o, x, y);
        e.z   = (e.res == 32'd0);
        e.lat = exp_latency(o, x, y);
        e.t   = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    endtask

    task automatic drain(input int hold);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("drain_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Monitor: compares every cycle out_valid is high, so stalled results must stay stable
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out_valid: got result %h with no pending op", result);
                end else begin
                    if (!prev_valid) check("latency", 32'(cyc - q[0].t + 1), 32'(q[0].lat));
                    check("result", result, q[0].res);
                    check("zero", {31'd0, zero}, {31'd0, q[0].z});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (flush && q.size() > 0) void'(q.pop_front());
            prev_valid <= out_valid;
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFFFFFD);       drain(0);
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF); drain(0);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); drain(0);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); drain(0);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);       drain(0);
        issue(3'd6, 32'hFFFFFFF9, 32'd2);       drain(0);
        issue(3'd5, 32'd100, 32'd7);            drain(0);
        issue(3'd7, 32'd100, 32'd7);            drain(5);
        issue(3'd5, 32'd5, 32'd0);              drain(0);
        issue(3'd7, 32'd5, 32'd0);              drain(0);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF); drain(0);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF); drain(3);

        // Flush at accept+10: unit idles next cycle and never presents a result
        issue(3'd5, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(3'd4, 32'hFFFFFF9C, 32'd7);       drain(1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                default: begin end
            endcase
            issue(ro, ra, rb);
            drain(int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of CALC
        issue(3'd0, 32'd123, 32'd456);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        q.delete();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        issue(3'd0, 32'd3, 32'd4);              drain(0);
        check("queue_empty", 32'(q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the full RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) that the single-cycle integer ALU leaves out. It sits beside the ALU in the execute stage. It takes operands through a valid/ready handshake, computes over XLEN cycles using a radix-2 shift-add/shift-subtract datapath, and holds the result until the pipeline accepts it. Flush support lets the pipeline kill an in-flight operation on a branch mispredict or trap.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  abort any in-flight operation; synchronous.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  unit can accept an operation (high only in IDLE).
- op  in  3  muldiv_op_t, RISC-V funct3 encoding: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- a, b  in  XLEN  rs1 and rs2 operands.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts the result this cycle.
- result  out  XLEN  operation result.
- zero  out  1  result == 0; meaningful only while out_valid.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch op, a, b.
  - Take absolute values of the signed operands: MULH (both), MULHSU (a only), DIV/REM (both).
  - Record result sign. For multiply it is the XOR of the operand signs; MULHSU uses sign(a) only. For DIV it is the XOR of the operand signs. For REM it is sign(a).
  - Go to CALC, except for the special cases below.
- Special cases bypass CALC and go straight to DONE with the result loaded:
  - Divide by zero (b==0): DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (DIV/REM, a==-2^(XLEN-1), b==-1): DIV gives a; REM gives 0.
  - No special cases exist for multiply.
- CALC: runs exactly XLEN iterations, counted by a $clog2(XLEN)+1-bit counter.
  - Multiply: 2*XLEN-bit product register; shift-add one multiplier bit per cycle.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, set a quotient bit.
- FIX: one cycle.
  - If the result sign is set, two's-complement negate the 2*XLEN product, quotient or remainder.
  - Select the output: MUL takes the low XLEN bits, MULH* the high XLEN bits, DIV* the quotient, REM* the remainder.
  - Load result; go to DONE.
- DONE: out_valid=1 and result is stable. On out_ready, return to IDLE. in_ready stays low throughout DONE.
- flush: in any state, go to IDLE on the next edge and drop out_valid; the result is discarded. Flush wins over in_valid in IDLE (no accept).
- zero = (result == 0), combinational from the result register.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, counter=0.

## Timing
- Accept happens at edge t (in_valid & in_ready).
- Normal path: CALC covers cycles t+1..t+XLEN, FIX is at t+XLEN+1, and out_valid rises at t+XLEN+2. For XLEN=32 that is 34 cycles.
- Special-case path: out_valid rises at t+1.
- Throughput: one operation in flight. A new accept is possible at the earliest one cycle after the out_valid & out_ready handshake.
- If reset is asserted mid-operation, all outputs take their reset values immediately (asynchronously).
- Operands may change after acceptance without effect.

## Structure
- muldiv_pkg holds:
  - muldiv_op_t enum (3-bit, funct3 values);
  - state enum muldiv_state_t;
  - helper functions is_signed_a(op), is_signed_b(op), is_div(op).
- Single module. No sub-module is needed: the shared shift datapath and the sign-fix logic are too tightly coupled to split cleanly.

## Test plan
All scenarios use XLEN=32.
1. MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept, zero=0.
2. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF at t+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0 with zero=1.
5. Backpressure and flush:
   - Hold out_ready low for 5 cycles in DONE: result stays stable, in_ready=0.
   - Assert flush at cycle t+10: the unit returns to IDLE next cycle, out_valid never rises, and the next op completes correctly.
6. Reset during CALC: out_valid=0, in_ready=1 and result=0 immediately. After release, a MUL 3*4 returns 12.
